// File: rtl/ecap5_dwbgpio.sv
// Pipelined Wishbone B4 GPIO responder: LED output register, debounced button
// inputs and sticky rising-edge flags with write-one-to-clear semantics.
module ecap5_dwbgpio #(
  parameter int NB_INPUTS       = 2,
  parameter int NB_OUTPUTS      = 2,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           wb_adr_i,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  output logic                  wb_ack_o,
  input  logic                  wb_cyc_i,
  output logic                  wb_stall_o,
  input  logic [NB_INPUTS-1:0]  gpio_i,
  output logic [NB_OUTPUTS-1:0] gpio_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                  req;
  logic                  wr;
  logic [11:0]           word;
  logic [31:0]           wmask;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic [NB_OUTPUTS-1:0] out_q;
  logic [NB_INPUTS-1:0]  sync_meta;
  logic [NB_INPUTS-1:0]  sync_q;
  logic [NB_INPUTS-1:0]  stable_q;
  logic [NB_INPUTS-1:0]  rise;
  logic [NB_INPUTS-1:0]  edge_q;
  logic [NB_INPUTS-1:0]  edge_clr;
  logic [CNT_W-1:0]      cnt_q [NB_INPUTS];
  logic                  ack_q;
  logic [31:0]           dat_q;
  logic                  unused_bits;

  assign req  = wb_cyc_i & wb_stb_i;
  assign wr   = req & wb_we_i;
  assign word = wb_adr_i[13:2];

  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{wb_sel_i[b]}};
    end
  end

  assign wdata = wb_dat_i & wmask;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= gpio_i;
      sync_q    <= sync_meta;
    end
  end

  // A bit is accepted once it has disagreed with the stable value for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_q <= '0;
      for (int i = 0; i < NB_INPUTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_INPUTS; i++) begin
        if (sync_q[i] != stable_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            stable_q[i] <= sync_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    rise = '0;
    for (int i = 0; i < NB_INPUTS; i++) begin
      rise[i] = sync_q[i] & ~stable_q[i] & (cnt_q[i] == CNT_LAST);
    end
  end

  assign edge_clr = (wr && word == 12'd2) ? wdata[NB_INPUTS-1:0] : '0;

  // OR-ing the new rise after the clear lets a same-cycle set beat the clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | rise;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= '0;
    end else if (wr && word == 12'd0) begin
      out_q <= (out_q & ~wmask[NB_OUTPUTS-1:0]) | wdata[NB_OUTPUTS-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      12'd0:   rdata[NB_OUTPUTS-1:0] = out_q;
      12'd1:   rdata[NB_INPUTS-1:0]  = stable_q;
      12'd2:   rdata[NB_INPUTS-1:0]  = edge_q;
      default: rdata = '0;
    endcase
  end

  // Every accepted request is answered exactly one cycle later with the
  // register contents as they were at acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= req ? rdata : '0;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign wb_stall_o = 1'b0;
  assign gpio_o     = out_q;

  assign unused_bits = ^{wb_adr_i[31:14], wb_adr_i[1:0], wdata, wmask};

endmodule

// File: tb/tb_ecap5_dwbgpio.sv
// Self-checking bench for ecap5_dwbgpio: directed scenarios plus randomized
// input/bus traffic compared against a window-based behavioural model.
module tb_ecap5_dwbgpio;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        stall;
  logic [1:0]  gpio;
  logic [1:0]  leds;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ecap5_dwbgpio #(
    .NB_INPUTS(2),
    .NB_OUTPUTS(2),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .wb_adr_i(adr),
    .wb_dat_o(rdat),
    .wb_dat_i(wdat),
    .wb_sel_i(sel),
    .wb_we_i(we),
    .wb_stb_i(stb),
    .wb_ack_o(ack),
    .wb_cyc_i(cyc),
    .wb_stall_o(stall),
    .gpio_i(gpio),
    .gpio_o(leds)
  );

  // Reference model: a bit flips once the DEB raw samples taken two or more
  // edges ago all disagree with the current accepted value.
  logic [1:0] m_out;
  logic [1:0] m_stable;
  logic [1:0] m_edge;
  logic [1:0] m_hist [0:DEB];

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [1:0] next_stable();
    logic [1:0] r;
    bit         all_diff;
    r = m_stable;
    for (int b = 0; b < 2; b++) begin
      all_diff = 1'b1;
      for (int k = 1; k <= DEB; k++) if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) r[b] = ~m_stable[b];
    end
    return r;
  endfunction

  function automatic logic [1:0] edge_clear();
    logic [31:0] v;
    v = wdat & bmask(sel);
    if (cyc && stb && we && adr[13:0] == 14'h8) return v[1:0];
    return 2'b00;
  endfunction

  function automatic logic [1:0] next_out();
    logic [31:0] m;
    logic [31:0] v;
    m = bmask(sel);
    v = (32'(m_out) & ~m) | (wdat & m);
    if (cyc && stb && we && adr[13:0] == 14'h0) return v[1:0];
    return m_out;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[13:0])
      14'h0:   return 32'(m_out);
      14'h4:   return 32'(m_stable);
      14'h8:   return 32'(m_edge);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_out    <= 2'b00;
      m_stable <= 2'b00;
      m_edge   <= 2'b00;
      for (int k = 0; k <= DEB; k++) m_hist[k] <= 2'b00;
    end else begin
      m_stable  <= next_stable();
      m_edge    <= (m_edge & ~edge_clear()) | (next_stable() & ~m_stable);
      m_out     <= next_out();
      m_hist[0] <= gpio;
      for (int k = 1; k <= DEB; k++) m_hist[k] <= m_hist[k-1];
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic got_ack,
                           output logic [31:0] got, output logic [31:0] exp);
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    adr  = a;
    wdat = d;
    sel  = s;
    exp  = model_read(a);
    @(negedge clk);
    got_ack = ack;
    got     = rdat;
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic test_reset();
    logic        a;
    logic [31:0] d;
    logic [31:0] e;
    rst = 1'b1; gpio = 2'b11; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0;
    wait_cycles(2);
    n_cmp++;
    if (ack !== 1'b0 || leds !== 2'b00 || rdat !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL reset_state: ack=%b leds=%b dat=%h, need 0/00/0", ack, leds, rdat);
    end
    rst = 1'b0;
    do_access(1'b0, 32'h4, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h0 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL reset_in_release: ack=%b dat=%h, need 1/00000000", a, d);
    end
    wait_cycles(4);
    do_access(1'b0, 32'h4, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h0 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL reset_in_early: ack=%b dat=%h, need 1/00000000", a, d);
    end
    do_access(1'b0, 32'h4, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h3 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL reset_in_settled: ack=%b dat=%h, need 1/00000003", a, d);
    end
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h3 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL reset_edge_settled: ack=%b dat=%h, need 1/00000003", a, d);
    end
  endtask

  task automatic test_out();
    logic        a;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] rd;
    logic [3:0]  rs;
    do_access(1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0001, a, d, e);
    n_cmp++;
    if (!a || leds !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL out_write: ack=%b leds=%b, need 1/11", a, leds);
    end
    do_access(1'b0, 32'h0, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h3) begin
      n_bad++;
      $display("[TB] FAIL out_readback: ack=%b dat=%h, need 1/00000003", a, d);
    end
    do_access(1'b1, 32'h0, 32'h0, 4'b1110, a, d, e);
    n_cmp++;
    if (!a || leds !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL out_sel_masked: ack=%b leds=%b, need 1/11", a, leds);
    end
    for (int i = 0; i < 8; i++) begin
      rd = $urandom;
      rs = 4'($urandom_range(0, 15));
      do_access(1'b1, 32'h0, rd, rs, a, d, e);
      n_cmp++;
      if (!a || leds !== m_out) begin
        n_bad++;
        $display("[TB] FAIL out_rand_write: ack=%b leds=%b, need 1/%b", a, leds, m_out);
      end
      do_access(1'b0, 32'h0, 32'h0, 4'hF, a, d, e);
      n_cmp++;
      if (!a || d !== e) begin
        n_bad++;
        $display("[TB] FAIL out_rand_read: ack=%b dat=%h, need 1/%h", a, d, e);
      end
    end
  endtask

  task automatic test_debounce();
    logic        a;
    logic [31:0] d;
    logic [31:0] e;
    int          hold;
    logic [31:0] ra;
    gpio = 2'b00;
    wait_cycles(DEB + 4);
    do_access(1'b1, 32'h8, 32'h3, 4'hF, a, d, e);
    gpio = 2'b01;
    wait_cycles(DEB - 1);
    gpio = 2'b00;
    wait_cycles(10);
    do_access(1'b0, 32'h4, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h0 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL glitch_in: ack=%b dat=%h, need 1/00000000", a, d);
    end
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h0 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL glitch_edge: ack=%b dat=%h, need 1/00000000", a, d);
    end
    gpio = 2'b01;
    wait_cycles(5);
    do_access(1'b0, 32'h4, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h0 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL pulse_in_early: ack=%b dat=%h, need 1/00000000", a, d);
    end
    do_access(1'b0, 32'h4, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h1 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL pulse_in_set: ack=%b dat=%h, need 1/00000001", a, d);
    end
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h1 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL pulse_edge_set: ack=%b dat=%h, need 1/00000001", a, d);
    end
    gpio = 2'b00;
    wait_cycles(DEB + 4);
    do_access(1'b0, 32'h4, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h0 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL release_in: ack=%b dat=%h, need 1/00000000", a, d);
    end
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h1 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL release_edge_sticky: ack=%b dat=%h, need 1/00000001", a, d);
    end
    hold = 0;
    for (int it = 0; it < 300; it++) begin
      if (hold == 0) begin
        gpio = 2'($urandom_range(0, 3));
        hold = int'($urandom_range(1, 8));
      end else begin
        hold--;
      end
      case ($urandom_range(0, 3))
        0: wait_cycles(1);
        1, 2: begin
          ra = ($urandom_range(0, 1) == 0) ? 32'h4 : 32'h8;
          do_access(1'b0, ra, 32'h0, 4'hF, a, d, e);
          n_cmp++;
          if (!a || d !== e) begin
            n_bad++;
            $display("[TB] FAIL rand_read @%h: ack=%b dat=%h, need 1/%h", ra, a, d, e);
          end
        end
        default: begin
          do_access(1'b1, 32'h8, $urandom, 4'($urandom_range(0, 15)), a, d, e);
          n_cmp++;
          if (!a) begin
            n_bad++;
            $display("[TB] FAIL rand_w1c_ack: ack=%b, need 1", a);
          end
        end
      endcase
    end
  endtask

  task automatic test_w1c();
    logic        a;
    logic [31:0] d;
    logic [31:0] e;
    gpio = 2'b00;
    wait_cycles(DEB + 4);
    do_access(1'b1, 32'h8, 32'h3, 4'hF, a, d, e);
    gpio = 2'b11;
    wait_cycles(DEB + 4);
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h3 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL w1c_both_set: ack=%b dat=%h, need 1/00000003", a, d);
    end
    do_access(1'b1, 32'h8, 32'h1, 4'b0001, a, d, e);
    do_access(1'b1, 32'h8, 32'h2, 4'b0000, a, d, e);
    do_access(1'b1, 32'h8, 32'hFFFF_FF00, 4'b0001, a, d, e);
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h2 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL w1c_clear_bit0: ack=%b dat=%h, need 1/00000002", a, d);
    end
    gpio = 2'b10;
    wait_cycles(DEB + 4);
    gpio = 2'b11;
    wait_cycles(5);
    do_access(1'b1, 32'h8, 32'h1, 4'b0001, a, d, e);
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h3 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL w1c_set_wins: ack=%b dat=%h, need 1/00000003", a, d);
    end
    do_access(1'b1, 32'h8, 32'h3, 4'hF, a, d, e);
    gpio = 2'b10;
    wait_cycles(DEB + 4);
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h0 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL fall_no_edge: ack=%b dat=%h, need 1/00000000", a, d);
    end
    gpio = 2'b11;
    wait_cycles(5);
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h0 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL read_at_set_pre: ack=%b dat=%h, need 1/00000000", a, d);
    end
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h1 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL read_at_set_post: ack=%b dat=%h, need 1/00000001", a, d);
    end
  endtask

  task automatic test_back_to_back();
    logic        a;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] expq [4];
    do_access(1'b1, 32'h0, 32'h2, 4'hF, a, d, e);
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        n_cmp++;
        if (ack !== 1'b1 || rdat !== expq[i-1] || stall !== 1'b0) begin
          n_bad++;
          $display("[TB] FAIL b2b_%0d: ack=%b stall=%b dat=%h, need 1/0/%h", i-1, ack, stall, rdat, expq[i-1]);
        end
      end
      if (i < 4) begin
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b0;
        sel  = 4'hF;
        adr  = (i == 3) ? 32'h10 : 32'(i * 4);
        expq[i] = model_read(adr);
      end else begin
        cyc = 1'b0;
        stb = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ack !== 1'b0 || rdat !== 32'h0 || expq[3] !== 32'h0 || expq[0] !== 32'h2) begin
      n_bad++;
      $display("[TB] FAIL b2b_tail: ack=%b dat=%h, need 0/00000000", ack, rdat);
    end
  endtask

  task automatic test_cyc_gating();
    logic        a;
    logic [31:0] d;
    logic [31:0] e;
    cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 32'h0; wdat = 32'h1; sel = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0 || leds !== 2'b10 || rdat !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL stb_no_cyc: ack=%b leds=%b dat=%h, need 0/10/0", ack, leds, rdat);
    end
    cyc = 1'b1; stb = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0 || leds !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL cyc_no_stb: ack=%b leds=%b, need 0/10", ack, leds);
    end
    cyc = 1'b0; we = 1'b0;
    do_access(1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF, a, d, e);
    n_cmp++;
    if (!a || leds !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL reserved_write: ack=%b leds=%b, need 1/10", a, leds);
    end
    do_access(1'b0, 32'hC, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL reserved_read: ack=%b dat=%h, need 1/00000000", a, d);
    end
  endtask

  task automatic test_reset_mid();
    logic        a;
    logic [31:0] d;
    logic [31:0] e;
    gpio = 2'b11;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; wdat = 32'h1; sel = 4'hF;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0 || leds !== 2'b00 || rdat !== 32'h0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset: ack=%b leds=%b dat=%h, need 0/00/0", ack, leds, rdat);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(5);
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h0 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL mid_edge_early: ack=%b dat=%h, need 1/00000000", a, d);
    end
    do_access(1'b0, 32'h8, 32'h0, 4'hF, a, d, e);
    n_cmp++;
    if (!a || d !== 32'h3 || d !== e) begin
      n_bad++;
      $display("[TB] FAIL mid_edge_set: ack=%b dat=%h, need 1/00000003", a, d);
    end
  endtask

  initial begin
    test_reset();
    test_out();
    test_debounce();
    test_w1c();
    test_back_to_back();
    test_cyc_gating();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ecap5_dwbgpio.md
Name: ecap5_dwbgpio

Overview:
- Pipelined Wishbone B4 slave (responder) GPIO peripheral; drives board LEDs and samples board buttons.
- Mapped behind the SoC address decoder; receives a 32-bit byte address with a 14-bit local offset (upper bits zero).
- Input path per pin: 2-FF synchronizer, then debounce counter, then sticky rising-edge flags.

Parameters:
- NB_INPUTS, 2, number of input pins (1..32).
- NB_OUTPUTS, 2, number of output pins (1..32).
- DEBOUNCE_CYCLES, 240000, consecutive stable cycles required to accept an input change; minimum 1; 240000 = 10 ms at 24 MHz.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset.
- wb_adr_i  in  32  byte address; only [13:2] decoded.
- wb_dat_o  out  32  read data.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables.
- wb_we_i  in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- wb_cyc_i  in  1  bus cycle.
- wb_stall_o  out  1  stall.
- gpio_i  in  NB_INPUTS  asynchronous inputs (buttons).
- gpio_o  out  NB_OUTPUTS  outputs (LEDs).

Behaviour:
- Clocking/reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: wb_ack_o=0, wb_dat_o=0, wb_stall_o=0, gpio_o=0, synchronizers=0, debounced state=0, counters=0, edge flags=0.
- Handshake:
  - wb_stall_o is tied 0.
  - A request is accepted on any cycle with wb_cyc_i & wb_stb_i.
  - wb_ack_o=1 exactly one cycle later; wb_dat_o is valid in the same cycle as the ack.
  - Back-to-back requests each get one ack on consecutive cycles.
  - wb_dat_o=0 when wb_ack_o=0.
  - stb without cyc is ignored.
- Register map (offset = wb_adr_i[13:0]):
  - 0x0 OUT, RW: bits [NB_OUTPUTS-1:0] drive gpio_o.
  - 0x4 IN, RO: debounced input state.
  - 0x8 EDGE, RW1C: sticky rising-edge flags.
  - 0xC reserved.
  - Offsets 0xC and above read 0; writes to them are ignored; they are still acked.
- Write rules:
  - Writes honour wb_sel_i per byte.
  - Bits beyond NB_* are ignored on write and read as 0.
  - A write to OUT updates gpio_o on the cycle after acceptance.
- Input path:
  - sync = 2-FF synchronizer of gpio_i, giving 2 cycles of latency.
  - Per bit, if sync != stable: the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 and sync still differs, stable <= sync and the counter is cleared.
  - Per bit, if sync == stable: the counter is cleared.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never wraps.
- Latency: a clean input transition is visible in IN 2+DEBOUNCE_CYCLES cycles after the gpio_i edge. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches IN.
- Edge flags:
  - A 0->1 transition of stable[i] sets EDGE[i].
  - Writing 1 to EDGE[i] (with the byte enabled) clears it; writing 0 has no effect.
  - If a set and a clear occur in the same cycle, the set wins.
  - A falling transition has no effect on EDGE.
- Read data is sampled at acceptance. A read coincident with an edge-set returns the pre-set value; the flag is visible on the next read.
- Reset mid-operation: a pending ack is dropped (ack=0 the cycle after rst_i), and all state returns to reset values. If an input is held high across reset release, EDGE is set 2+DEBOUNCE_CYCLES cycles after release.

Test Plan:
- Reset: assert rst_i 2 cycles with gpio_i=2'b11 -> ack=0, gpio_o=0, IN reads 0 immediately after release. With DEBOUNCE_CYCLES=4, IN=3 and EDGE=3 after 6 cycles.
- OUT write/readback: write 0x0 dat=0xFFFFFFFF sel=4'b0001 -> ack next cycle, gpio_o=2'b11, read 0x0 returns 0x00000003. Write with sel=4'b1110 -> gpio_o unchanged.
- Debounce (DEBOUNCE_CYCLES=4): 3-cycle pulse on gpio_i[0] -> IN stays 0, EDGE stays 0. A 10-cycle pulse -> IN[0]=1 in cycle 6 after the rising edge, EDGE[0]=1. IN[0] returns to 0 after release; EDGE[0] stays 1.
- W1C: with EDGE=0x3, write 0x8 dat=0x1 -> EDGE reads 0x2. Same cycle as a new rising edge on bit 0 -> EDGE[0] remains 1.
- Pipelining: 4 consecutive accepted reads (OUT, IN, EDGE, 0x10) with stb held -> 4 acks on consecutive cycles, stall=0 throughout, data in order, 0x10 returns 0.
- cyc=0 with stb=1 -> no ack, no register change.
